// File: rtl/dmem_responder_if.sv
// MEM-stage data-port bundle between the core (master) and dmem_responder (slave).
interface dmem_responder_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        memwrite;
    logic        memread;
    logic [31:0] rdata;
    logic        busy;

    modport master (
        output addr, wdata, memwrite, memread,
        input  rdata, busy
    );

    modport slave (
        input  addr, wdata, memwrite, memread,
        output rdata, busy
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: posted in-order store buffer draining into a word array.
// Optional macro DMEM_BYPASS_EN: loads forward youngest matching pending store instead of stalling.
module dmem_responder #(
    parameter int ADDR_W   = 10,
    parameter int SB_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    dmem_responder_if.slave           bus,
    output logic [$clog2(SB_DEPTH):0] sb_count
);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] sb_addr [SB_DEPTH];
    logic [31:0]       sb_data [SB_DEPTH];
    logic [31:0]       mem     [2**ADDR_W];

    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;

    logic [ADDR_W-1:0] a_idx;
    logic              load;
    logic              full_stall;
    logic              hit;
    logic [PW-1:0]     idx;
    logic              push;
    logic              pop;
    logic              busy;
    logic [31:0]       rdata;
    logic              unused_addr_hi;

    assign a_idx          = bus.addr[ADDR_W-1:0];
    assign unused_addr_hi = ^bus.addr[31:ADDR_W];
    assign load           = bus.memread & ~bus.memwrite;
    assign full_stall     = (count == CW'(SB_DEPTH)) & bus.memwrite;

`ifdef DMEM_BYPASS_EN
    logic [31:0] hit_data;

    // Scan oldest to newest so the last match seen (youngest) wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count && sb_addr[idx] == a_idx) begin
                hit      = 1'b1;
                hit_data = sb_data[idx];
            end
        end
    end

    assign busy  = full_stall;
    assign rdata = !load ? '0 : (hit ? hit_data : mem[a_idx]);
`else
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count && sb_addr[idx] == a_idx) begin
                hit = 1'b1;
            end
        end
    end

    // A load hitting a pending store stalls and force-drains until the array is current.
    assign busy  = full_stall | (load & hit);
    assign rdata = load ? mem[a_idx] : '0;
`endif

    assign push      = bus.memwrite & ~busy;
    assign pop       = (count != '0) & (~bus.memread | busy);
    assign bus.busy  = busy;
    assign bus.rdata = rdata;
    assign sb_count  = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage and the word array carry no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr[tail] <= a_idx;
            sb_data[tail] <= bus.wdata;
        end
        if (pop) begin
            mem[sb_addr[head]] <= sb_data[head];
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: driver queues expectations, negedge monitor checks them.
module tb_dmem_responder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] sb_count;

    dmem_responder_if bus();

    dmem_responder #(.ADDR_W(10), .SB_DEPTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .sb_count (sb_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          chk_rd;
        logic [31:0] rd;
        logic        bsy;
        logic [2:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    bit   chk_now = 1'b0;
    int   n_vec   = 0;
    int   n_bad   = 0;
    logic [31:0] model [int];

    task automatic drive(input logic r, input logic we, input logic re,
                         input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        rst          = r;
        bus.memwrite = we;
        bus.memread  = re;
        bus.addr     = a;
        bus.wdata    = d;
        chk_now      = 1'b0;
    endtask

    task automatic expect_now(input string nm, input bit crd, input logic [31:0] erd,
                              input logic eb, input logic [2:0] ec);
        exp_t e;
        e.name = nm; e.chk_rd = crd; e.rd = erd; e.bsy = eb; e.cnt = ec;
        exp_q.push_back(e);
        chk_now = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            n_vec++;
            if (sb_count > 3'd4) begin
                n_bad++;
                $display("FAIL sb_count_bound: got %0d, limit 4", sb_count);
            end
        end
        if (chk_now) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL scoreboard_empty: got no expectation, required one");
            end else begin
                e = exp_q.pop_front();
                if (bus.busy !== e.bsy) begin
                    n_bad++;
                    $display("FAIL %s busy: got %0b, required %0b", e.name, bus.busy, e.bsy);
                end
                n_vec++;
                if (sb_count !== e.cnt) begin
                    n_bad++;
                    $display("FAIL %s sb_count: got %0d, required %0d", e.name, sb_count, e.cnt);
                end
                if (e.chk_rd) begin
                    n_vec++;
                    if (bus.rdata !== e.rd) begin
                        n_bad++;
                        $display("FAIL %s rdata: got %h, required %h", e.name, bus.rdata, e.rd);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        bus.memwrite = 1'b0; bus.memread = 1'b0; bus.addr = '0; bus.wdata = '0;

        drive(0, 0, 0, 0, 0);                 expect_now("reset_state", 1, 32'h0, 0, 0);
        drive(1, 0, 0, 0, 0);                 expect_now("idle_rdata", 1, 32'h0, 0, 0);

        // store then load of addr 5
        drive(1, 1, 0, 5, 32'hDEADBEEF);      expect_now("st5", 1, 32'h0, 0, 0);
        drive(1, 0, 1, 5, 0);
`ifdef DMEM_BYPASS_EN
        expect_now("ld5_bypass", 1, 32'hDEADBEEF, 0, 1);
        drive(1, 0, 0, 0, 0);                 expect_now("drain5", 1, 32'h0, 0, 1);
`else
        expect_now("ld5_busy", 0, 32'h0, 1, 1);
        drive(1, 0, 1, 5, 0);                 expect_now("ld5_after", 1, 32'hDEADBEEF, 0, 0);
`endif
        drive(1, 0, 1, 5, 0);                 expect_now("ld5_array", 1, 32'hDEADBEEF, 0, 0);

        // youngest wins on addr 9
        drive(1, 1, 1, 9, 32'h1);             expect_now("st9_1", 1, 32'h0, 0, 0);
        drive(1, 1, 1, 9, 32'h2);             expect_now("st9_2", 1, 32'h0, 0, 1);
        drive(1, 1, 1, 9, 32'h3);             expect_now("st9_3", 1, 32'h0, 0, 2);
        drive(1, 0, 1, 9, 0);
`ifdef DMEM_BYPASS_EN
        expect_now("ld9_young", 1, 32'h3, 0, 3);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0);             expect_now("drain9", 1, 32'h0, 0, 3'(3 - i));
        end
`else
        expect_now("ld9_busy3", 0, 32'h0, 1, 3);
        drive(1, 0, 1, 9, 0);                 expect_now("ld9_busy2", 0, 32'h0, 1, 2);
        drive(1, 0, 1, 9, 0);                 expect_now("ld9_busy1", 0, 32'h0, 1, 1);
        drive(1, 0, 1, 9, 0);                 expect_now("ld9_young", 1, 32'h3, 0, 0);
`endif

        // full buffer with memread held high
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 1, 32'(20 + k), 32'h100 + 32'(k));
            expect_now("fill", 1, 32'h0, 0, 3'(k));
        end
        drive(1, 1, 1, 2, 32'h5555_0005);     expect_now("full_busy", 1, 32'h0, 1, 4);
        drive(1, 1, 1, 2, 32'h5555_0005);     expect_now("full_accept", 1, 32'h0, 0, 3);
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 0, 0);
            expect_now("full_drain", 1, 32'h0, 0, (k < 4) ? 3'(4 - k) : 3'd0);
        end
        drive(1, 0, 1, 2, 0);                 expect_now("full_arr2", 1, 32'h5555_0005, 0, 0);
        drive(1, 0, 1, 20, 0);                expect_now("full_arr20", 1, 32'h100, 0, 0);

        // wrap-around: 12 stores, pattern store(re=1), store(re=0), idle
        for (int i = 0; i < 12; i += 2) begin
            a = 32'(100 + 7 * i);       d = 32'hC000_0000 + 32'(i * 32'h111);
            model[100 + 7 * i] = d;
            drive(1, 1, 1, a, d);             expect_now("wrap_st_a", 1, 32'h0, 0, 0);
            a = 32'(100 + 7 * (i + 1)); d = 32'hC000_0000 + 32'((i + 1) * 32'h111);
            model[100 + 7 * (i + 1)] = d;
            drive(1, 1, 0, a, d);             expect_now("wrap_st_b", 1, 32'h0, 0, 1);
            drive(1, 0, 0, 0, 0);             expect_now("wrap_idle", 1, 32'h0, 0, 1);
        end
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 1, 32'(100 + 7 * i), 0);
            expect_now("wrap_ld", 1, model[100 + 7 * i], 0, 0);
        end

        // address truncation
        drive(1, 1, 0, 32'h0000_0403, 32'hA5A5A5A5); expect_now("trunc_st", 1, 32'h0, 0, 0);
        drive(1, 0, 0, 0, 0);                 expect_now("trunc_idle", 1, 32'h0, 0, 1);
        drive(1, 0, 1, 3, 0);                 expect_now("trunc_ld", 1, 32'hA5A5A5A5, 0, 0);

        // reset mid-operation discards pending stores
        for (int k = 0; k < 3; k++) drive(1, 1, 0, 32'(40 + k), 32'h1111_0040 + 32'(k));
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);                 expect_now("pre_idle", 1, 32'h0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 1, 32'(40 + k), 32'h2222_0040 + 32'(k));
            expect_now("rst_fill", 1, 32'h0, 0, 3'(k));
        end
        drive(0, 0, 0, 0, 0);                 expect_now("rst_mid", 1, 32'h0, 0, 0);
        drive(1, 0, 0, 0, 0);                 expect_now("rst_release", 1, 32'h0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 32'(40 + k), 0);
            expect_now("rst_old", 1, 32'h1111_0040 + 32'(k), 0, 0);
        end

        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d leftover, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the five-stage pipelined core: it sits on the core's MEM-stage data port, taking the ALU address, store data and memwrite/memread strobes, and returns load data on the same cycle for capture into MEMWB. Stores are posted into a small in-order store buffer and drained into a single-ported word array when the array port is free. Loads bypass pending stores so the core always sees program-order data.

## Interface
- ADDR_W, 10, word-address width; array holds 2^ADDR_W 32-bit words
- SB_DEPTH, 4, store-buffer entries; power of two, 2..8

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- addr  input  32  word address from the core's MEM stage (alu_DMEM); bits [ADDR_W-1:0] used, upper bits ignored
- wdata  input  32  store data (writedata_DMEM)
- memwrite  input  1  store request this cycle
- memread  input  1  load request this cycle
- rdata  output  32  load data (readdata_MEM), combinational from addr
- busy  output  1  responder cannot accept the current request; core must hold the MEM-stage request unchanged
- sb_count  output  $clog2(SB_DEPTH)+1  current store-buffer occupancy

## Operation
- Store buffer: circular FIFO of {addr[ADDR_W-1:0], wdata}, head/tail pointers plus count; entries are never merged or dropped.
- Accepted store: memwrite=1 and busy=0 → entry pushed at tail on the clock edge.
- Drain: head entry written to the array and popped when count>0 and the array port is free. Port is free when memread=0, or when a drain is forced (see busy).
- Load with count=0 or no address match: rdata = array[addr].
- Load matching a pending entry: `DMEM_BYPASS_EN` behaviour (see Configuration).
- memread=0: rdata = 0.
- memread=1 and memwrite=1 together: treated as a store; rdata = 0. The core never issues both; the bench checks this defined value.
- busy=1 when count==SB_DEPTH and memwrite=1; that cycle the head is force-drained, even if memread=1.
- Push and pop on the same edge leave count unchanged. Pointers wrap modulo SB_DEPTH.
- The array is not reset; its contents after reset are undefined.

## Timing
- Reset (rst low, asynchronous): head=tail=0, count=0, busy=0, sb_count=0. A reset mid-drain discards all pending stores.
- Load latency: 0 cycles. rdata is valid in the same cycle as addr/memread, before the edge on which MEMWB captures it.
- Store visibility: a store is readable through bypass from the next cycle. It reaches the array no earlier than 1 cycle after acceptance.
- Drain rate: at most 1 entry per cycle.
- Full buffer with a store: busy is asserted for exactly 1 cycle. On that edge, the head is drained and the store is not pushed. On the next cycle, with the request held, busy=0 and the store is pushed.
- Array write and bypass use the registered entry value. A drain of address A on an edge and a load of A in the next cycle return identical data.

## Configuration
- `DMEM_BYPASS_EN` defined:
  - A load searches valid entries newest-first and returns the youngest matching data.
  - busy is never asserted for loads.
- `DMEM_BYPASS_EN` undefined:
  - A load whose address matches any pending entry asserts busy. The head is force-drained each such cycle.
  - rdata = array[addr], possibly stale, while busy=1.
  - Once no entry matches, busy drops and rdata returns the correct value.
  - No comparator-to-data mux is built.

## Test plan
- Reset: hold rst=0 mid-operation with count=3 → sb_count=0 and busy=0 immediately; release; a load of any previously buffered address returns the array's pre-store value.
- Store-then-load: store 0xDEADBEEF to addr 5; load addr 5 the next cycle.
  - With bypass: rdata=0xDEADBEEF, busy=0.
  - Without bypass: busy=1 for 1 cycle, then rdata=0xDEADBEEF.
- Youngest-wins: consecutive stores of 0x1, 0x2, 0x3 to addr 9; load addr 9 while memread stays high (no drain) → rdata=0x3; sb_count=3.
- Full buffer: SB_DEPTH stores with memread=1 throughout, then a 5th store to addr 2 → busy=1 for 1 cycle, sb_count stays 4, then the store is accepted; after 5 idle cycles, array[2] holds the 5th value and sb_count=0.
- Wrap-around: 3×SB_DEPTH stores to distinct addresses interleaved with idle cycles → the array matches a reference model in program order; sb_count never exceeds SB_DEPTH.
- Address truncation: store 0xA5A5A5A5 to addr 0x0000_0403 with ADDR_W=10; load addr 3 → rdata=0xA5A5A5A5.
